// File: rtl/ip_cksum_sched_pkg.sv
`default_nettype none
// ============================================================================
// Module      : ip_cksum_sched_pkg
// Description : Shared types and constants for the IP checksum scheduler.
// Revision    : 1.0 - initial release
// ============================================================================
package ip_cksum_sched_pkg;

    // Scheduler FSM encoding
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ADD  = 2'd1,
        ST_FOLD = 2'd2,
        ST_RESP = 2'd3
    } state_t;

    // Number of end-around-carry folds needed to squeeze a 34-bit sum to 16 bits
    localparam int FOLD_CYCLES = 3;
    localparam int CKSUM_WIDTH = 16;
    localparam int OPS_PER_REQ = 4;

    // Width of a requester index; never zero, even for a single requester
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/ip_cksum_sched_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : rr_arbiter
// Description : Combinational round-robin picker. The search starts one past
//               the previous owner and wraps, so every requester is reached
//               within NUM_REQ grants.
// Revision    : 1.0 - initial release
// ============================================================================
module rr_arbiter
    import ip_cksum_sched_pkg::*;
#(
    parameter int NUM_REQ = 2,
    parameter int IDX_W   = idx_width(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   last_owner,
    output logic [NUM_REQ-1:0] gnt,
    output logic [IDX_W-1:0]   gnt_idx
);

    logic [IDX_W:0]   w_cand_sum;
    logic [IDX_W-1:0] w_cand;
    logic             w_found;

    // Walk the candidates in priority order and keep the first active one
    always_comb begin
        gnt        = '0;
        gnt_idx    = '0;
        w_found    = 1'b0;
        w_cand_sum = '0;
        w_cand     = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            // last_owner < NUM_REQ and k <= NUM_REQ, so one subtraction wraps
            w_cand_sum = {1'b0, last_owner} + (IDX_W+1)'(k);
            if (w_cand_sum >= (IDX_W+1)'(NUM_REQ)) begin
                w_cand_sum = w_cand_sum - (IDX_W+1)'(NUM_REQ);
            end
            w_cand = w_cand_sum[IDX_W-1:0];
            if (!w_found && req[w_cand]) begin
                gnt[w_cand] = 1'b1;
                gnt_idx     = w_cand;
                w_found     = 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/ip_cksum_sched.sv
`default_nettype none
// ============================================================================
// Module      : ip_cksum_sched
// Description : Shares one one's-complement checksum engine between NUM_REQ
//               requesters. Captures four partial sums, adds them, folds the
//               carries back three times and returns the inverted result.
// Revision    : 1.0 - initial release
// ============================================================================
module ip_cksum_sched
    import ip_cksum_sched_pkg::*;
#(
    parameter int NUM_REQ   = 2,
    parameter int SUM_WIDTH = 32
) (
    input  logic                                   AXI_ACLK,
    input  logic                                   AXI_RESETN,
    input  logic [NUM_REQ-1:0]                     req,
    input  logic [NUM_REQ*OPS_PER_REQ*SUM_WIDTH-1:0] req_sum,
    output logic [NUM_REQ-1:0]                     gnt,
    output logic [NUM_REQ-1:0]                     rslt_valid,
    input  logic [NUM_REQ-1:0]                     rslt_ready,
    output logic [CKSUM_WIDTH-1:0]                 rslt_cksum,
    output logic                                   busy,
    output logic [31:0]                            done_count
);

    localparam int               IDX_W       = idx_width(NUM_REQ);
    localparam int               ACC_W       = SUM_WIDTH + 2;
    localparam int               BLK_W       = OPS_PER_REQ * SUM_WIDTH;
    localparam logic [1:0]       C_FOLD_LAST = 2'(FOLD_CYCLES - 1);
    localparam logic [IDX_W-1:0] C_LAST_RST  = IDX_W'(NUM_REQ - 1);

    state_t               r_state;
    state_t               w_state_nxt;
    logic [IDX_W-1:0]     r_owner;
    logic [IDX_W-1:0]     r_last_owner;
    logic [SUM_WIDTH-1:0] r_ops [OPS_PER_REQ];
    logic [ACC_W-1:0]     r_acc;
    logic [1:0]           r_fold_cnt;
    logic [31:0]          r_done_count;

    logic [NUM_REQ-1:0]   w_arb_gnt;
    logic [IDX_W-1:0]     w_arb_idx;
    logic [BLK_W-1:0]     w_win_ops;
    logic [ACC_W-1:0]     w_add_sum;
    logic [ACC_W-1:0]     w_fold_sum;
    logic                 w_capture;
    logic                 w_handshake;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_rr_arbiter (
        .req        (req),
        .last_owner (r_last_owner),
        .gnt        (w_arb_gnt),
        .gnt_idx    (w_arb_idx)
    );

    assign w_win_ops  = req_sum[w_arb_idx * BLK_W +: BLK_W];
    assign w_fold_sum = ACC_W'(r_acc[CKSUM_WIDTH-1:0]) + ACC_W'(r_acc[ACC_W-1:CKSUM_WIDTH]);
    assign busy       = (r_state != ST_IDLE);
    assign done_count = r_done_count;

    // Full-width sum of the captured operands; two guard bits absorb every carry
    always_comb begin
        w_add_sum = '0;
        for (int j = 0; j < OPS_PER_REQ; j++) begin
            w_add_sum = w_add_sum + ACC_W'(r_ops[j]);
        end
    end

    // Next-state decode plus the per-state output pulses
    always_comb begin
        w_state_nxt = r_state;
        gnt         = '0;
        rslt_valid  = '0;
        rslt_cksum  = '0;
        w_capture   = 1'b0;
        w_handshake = 1'b0;
        case (r_state)
            ST_IDLE: begin
                // No grant can escape while reset is being applied
                if (AXI_RESETN && (|req)) begin
                    gnt         = w_arb_gnt;
                    w_capture   = 1'b1;
                    w_state_nxt = ST_ADD;
                end
            end
            ST_ADD: begin
                w_state_nxt = ST_FOLD;
            end
            ST_FOLD: begin
                if (r_fold_cnt == C_FOLD_LAST) begin
                    w_state_nxt = ST_RESP;
                end
            end
            ST_RESP: begin
                rslt_valid = NUM_REQ'(1) << r_owner;
                rslt_cksum = ~r_acc[CKSUM_WIDTH-1:0];
                // Only the owner's ready bit can complete the handshake
                if (rslt_ready[r_owner]) begin
                    w_handshake = 1'b1;
                    w_state_nxt = ST_IDLE;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // FSM state register
    always_ff @(posedge AXI_ACLK) begin
        if (!AXI_RESETN) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Operand capture, accumulate/fold datapath and handshake counter
    always_ff @(posedge AXI_ACLK) begin
        if (!AXI_RESETN) begin
            r_owner      <= '0;
            r_last_owner <= C_LAST_RST;
            r_acc        <= '0;
            r_fold_cnt   <= '0;
            r_done_count <= '0;
            for (int j = 0; j < OPS_PER_REQ; j++) begin
                r_ops[j] <= '0;
            end
        end else begin
            if (w_capture) begin
                r_owner      <= w_arb_idx;
                r_last_owner <= w_arb_idx;
                for (int j = 0; j < OPS_PER_REQ; j++) begin
                    r_ops[j] <= w_win_ops[j*SUM_WIDTH +: SUM_WIDTH];
                end
            end
            if (r_state == ST_ADD) begin
                r_acc <= w_add_sum;
            end
            if (r_state == ST_FOLD) begin
                r_acc      <= w_fold_sum;
                r_fold_cnt <= (r_fold_cnt == C_FOLD_LAST) ? 2'd0 : r_fold_cnt + 2'd1;
            end
            if (w_handshake) begin
                r_done_count <= r_done_count + 32'd1;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_ip_cksum_sched.sv
`default_nettype none
// ============================================================================
// Module      : tb_ip_cksum_sched
// Description : Self-checking bench for ip_cksum_sched: directed scenarios and
//               a randomized run against a transaction-level reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ip_cksum_sched;

    localparam int NUM_REQ   = 2;
    localparam int SUM_WIDTH = 32;
    localparam int OPS_W     = 4 * SUM_WIDTH;

    logic                       AXI_ACLK = 1'b0;
    logic                       AXI_RESETN;
    logic [NUM_REQ-1:0]         req;
    logic [NUM_REQ*OPS_W-1:0]   req_sum;
    logic [NUM_REQ-1:0]         gnt;
    logic [NUM_REQ-1:0]         rslt_valid;
    logic [NUM_REQ-1:0]         rslt_ready;
    logic [15:0]                rslt_cksum;
    logic                       busy;
    logic [31:0]                done_count;

    int checks   = 0;
    int failures = 0;

    always #5 AXI_ACLK = ~AXI_ACLK;

    ip_cksum_sched #(
        .NUM_REQ   (NUM_REQ),
        .SUM_WIDTH (SUM_WIDTH)
    ) dut (
        .AXI_ACLK   (AXI_ACLK),
        .AXI_RESETN (AXI_RESETN),
        .req        (req),
        .req_sum    (req_sum),
        .gnt        (gnt),
        .rslt_valid (rslt_valid),
        .rslt_ready (rslt_ready),
        .rslt_cksum (rslt_cksum),
        .busy       (busy),
        .done_count (done_count)
    );

    // ---------------- reference model (transaction level) ----------------
    int           m_last;
    int           m_owner;
    int           m_age;
    bit           m_busy;
    logic [15:0]  m_ck;
    logic [31:0]  m_done;

    logic [NUM_REQ-1:0] exp_gnt;
    logic [NUM_REQ-1:0] exp_valid;
    logic [15:0]        exp_ck;
    logic               exp_busy;
    logic [31:0]        exp_done;

    // Internet checksum of four operands: add, fold carries until none, invert
    function automatic logic [15:0] ref_cksum(input logic [OPS_W-1:0] ops);
        longint unsigned s;
        s = 0;
        for (int j = 0; j < 4; j++) s += 64'(ops[j*SUM_WIDTH +: SUM_WIDTH]);
        while ((s >> 16) != 0) s = (s & 64'hFFFF) + (s >> 16);
        return ~s[15:0];
    endfunction

    function automatic void model_reset();
        m_last  = NUM_REQ - 1;
        m_owner = 0;
        m_age   = 0;
        m_busy  = 1'b0;
        m_ck    = '0;
        m_done  = '0;
    endfunction

    // Expected outputs for the current cycle given current inputs, then advance
    function automatic void model_cycle();
        exp_gnt   = '0;
        exp_valid = '0;
        exp_ck    = '0;
        exp_busy  = m_busy;
        exp_done  = m_done;
        if (!m_busy) begin
            for (int k = 1; k <= NUM_REQ; k++) begin
                int i;
                i = (m_last + k) % NUM_REQ;
                if (req[i] && exp_gnt == '0) begin
                    exp_gnt[i] = 1'b1;
                    m_owner    = i;
                    m_last     = i;
                    m_ck       = ref_cksum(req_sum[i*OPS_W +: OPS_W]);
                    m_busy     = 1'b1;
                    m_age      = 1;
                end
            end
        end else begin
            if (m_age >= 5) begin
                exp_valid[m_owner] = 1'b1;
                exp_ck             = m_ck;
                if (rslt_ready[m_owner]) begin
                    m_done = m_done + 32'd1;
                    m_busy = 1'b0;
                end
            end
            m_age++;
        end
    endfunction

    // ---------------- stimulus helpers (no comparisons) ----------------
    task automatic step();
        @(posedge AXI_ACLK);
        #1;
    endtask

    task automatic apply_reset();
        AXI_RESETN = 1'b0;
        req        = '0;
        step();
        AXI_RESETN = 1'b1;
        model_reset();
    endtask

    task automatic rand_sums();
        for (int w = 0; w < NUM_REQ*4; w++)
            req_sum[w*32 +: 32] = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFFF : $urandom;
    endtask

    // Runs one operation for requester r; lat = -1 if grant or result never came
    task automatic run_op(input int r, input logic [OPS_W-1:0] ops,
                          output logic [15:0] ck, output int lat);
        int t;
        req_sum[r*OPS_W +: OPS_W] = ops;
        req        = '0;
        req[r]     = 1'b1;
        rslt_ready = '1;
        lat        = -1;
        ck         = '0;
        t          = 0;
        #1;
        while (gnt[r] !== 1'b1 && t < 20) begin step(); #1; t++; end
        if (gnt[r] !== 1'b1) begin req = '0; return; end
        step();
        req = '0;
        t   = 1;
        #1;
        while (rslt_valid[r] !== 1'b1 && t < 20) begin step(); #1; t++; end
        if (rslt_valid[r] === 1'b1) begin
            lat = t;
            ck  = rslt_cksum;
        end
        step();
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        AXI_RESETN = 1'b0;
        req        = '1;
        rslt_ready = '1;
        step();
        step();
        #1;
        checks++; if (gnt !== '0)        begin failures++; $display("FAIL reset_gnt: got %b, expected 00", gnt); end
        checks++; if (rslt_valid !== '0) begin failures++; $display("FAIL reset_valid: got %b, expected 00", rslt_valid); end
        checks++; if (busy !== 1'b0)     begin failures++; $display("FAIL reset_busy: got %b, expected 0", busy); end
        checks++; if (rslt_cksum !== 16'h0000) begin failures++; $display("FAIL reset_cksum: got %h, expected 0000", rslt_cksum); end
        checks++; if (done_count !== 32'd0)    begin failures++; $display("FAIL reset_done: got %h, expected 00000000", done_count); end
        req        = '0;
        AXI_RESETN = 1'b1;
        model_reset();
        step();
    endtask

    task automatic test_single();
        req_sum    = '0;
        req_sum[31:0]  = 32'h0001_0002;
        req_sum[63:32] = 32'h0003_0004;
        req        = 2'b01;
        rslt_ready = '1;
        for (int c = 0; c <= 6; c++) begin
            #1;
            if (c == 0) begin
                checks++; if (gnt !== 2'b01) begin failures++; $display("FAIL single_gnt: got %b, expected 01", gnt); end
            end else if (c <= 4) begin
                checks++;
                if (rslt_valid !== 2'b00 || busy !== 1'b1) begin
                    failures++; $display("FAIL single_inflight c%0d: got valid=%b busy=%b, expected valid=00 busy=1", c, rslt_valid, busy);
                end
            end else if (c == 5) begin
                checks++; if (rslt_valid !== 2'b01) begin failures++; $display("FAIL single_latency: got valid=%b, expected 01", rslt_valid); end
                checks++; if (rslt_cksum !== 16'hFFF5) begin failures++; $display("FAIL single_cksum: got %h, expected fff5", rslt_cksum); end
            end else begin
                checks++; if (done_count !== 32'd1) begin failures++; $display("FAIL single_done: got %0d, expected 1", done_count); end
                checks++; if (busy !== 1'b0) begin failures++; $display("FAIL single_idle: got busy=%b, expected 0", busy); end
            end
            step();
            req = '0;
        end
    endtask

    task automatic test_fold();
        logic [15:0] ck;
        int lat;
        run_op(0, {4{32'hFFFF_FFFF}}, ck, lat);
        checks++; if (ck !== 16'h0000) begin failures++; $display("FAIL fold_all_ones: got %h, expected 0000", ck); end
        checks++; if (lat != 5) begin failures++; $display("FAIL fold_latency: got %0d, expected 5", lat); end
        run_op(1, '0, ck, lat);
        checks++; if (ck !== 16'hFFFF) begin failures++; $display("FAIL fold_all_zero: got %h, expected ffff", ck); end
    endtask

    task automatic test_contention();
        int gcount;
        int last_t;
        gcount = 0;
        last_t = -1;
        apply_reset();
        step();
        rand_sums();
        req        = '1;
        rslt_ready = '1;
        for (int t = 0; t < 24; t++) begin
            #1;
            model_cycle();
            if (gnt !== '0) begin
                checks++;
                if (gnt !== (NUM_REQ'(1) << (gcount % NUM_REQ))) begin
                    failures++; $display("FAIL contention_order #%0d: got %b, expected %b", gcount, gnt, NUM_REQ'(1) << (gcount % NUM_REQ));
                end
                if (gcount > 0) begin
                    checks++;
                    if (t - last_t != 6) begin failures++; $display("FAIL contention_interval: got %0d, expected 6", t - last_t); end
                end
                last_t = t;
                gcount++;
            end
            checks++;
            if (rslt_valid !== exp_valid || rslt_cksum !== exp_ck) begin
                failures++; $display("FAIL contention_result t%0d: got valid=%b ck=%h, expected valid=%b ck=%h", t, rslt_valid, rslt_cksum, exp_valid, exp_ck);
            end
            step();
        end
        checks++; if (gcount != 4) begin failures++; $display("FAIL contention_count: got %0d, expected 4", gcount); end
        req = '0;
    endtask

    task automatic test_backpressure();
        rand_sums();
        req        = 2'b10;
        rslt_ready = 2'b01;
        for (int t = 0; t < 24; t++) begin
            if (t == 1)  req = 2'b11;
            if (t == 15) rslt_ready = 2'b11;
            if (t == 17) req = 2'b00;
            if (t >= 2 && t <= 14) rand_sums();
            #1;
            model_cycle();
            checks++;
            if (gnt !== exp_gnt) begin failures++; $display("FAIL bp_gnt t%0d: got %b, expected %b", t, gnt, exp_gnt); end
            checks++;
            if (rslt_valid !== exp_valid || rslt_cksum !== exp_ck) begin
                failures++; $display("FAIL bp_result t%0d: got valid=%b ck=%h, expected valid=%b ck=%h", t, rslt_valid, rslt_cksum, exp_valid, exp_ck);
            end
            if (t >= 5 && t <= 14) begin
                checks++;
                if (rslt_valid !== 2'b10) begin failures++; $display("FAIL bp_hold t%0d: got %b, expected 10", t, rslt_valid); end
            end
            if (t == 16) begin
                checks++;
                if (gnt !== 2'b01) begin failures++; $display("FAIL bp_regrant: got %b, expected 01", gnt); end
            end
            step();
        end
    endtask

    task automatic test_reset_fold();
        rand_sums();
        req        = 2'b01;
        rslt_ready = '1;
        #1;
        checks++; if (gnt !== 2'b01) begin failures++; $display("FAIL rstfold_gnt: got %b, expected 01", gnt); end
        step();
        req = '0;
        step();
        step();
        AXI_RESETN = 1'b0;
        step();
        AXI_RESETN = 1'b1;
        model_reset();
        #1;
        checks++;
        if (gnt !== '0 || rslt_valid !== '0 || busy !== 1'b0 || rslt_cksum !== 16'h0 || done_count !== 32'd0) begin
            failures++; $display("FAIL rstfold_outputs: got gnt=%b valid=%b busy=%b ck=%h done=%h, expected all zero", gnt, rslt_valid, busy, rslt_cksum, done_count);
        end
        for (int t = 0; t < 8; t++) begin
            step();
            #1;
            checks++;
            if (rslt_valid !== '0) begin failures++; $display("FAIL rstfold_novalid t%0d: got %b, expected 00", t, rslt_valid); end
        end
        step();
        rand_sums();
        req = 2'b10;
        for (int t = 0; t < 7; t++) begin
            #1;
            model_cycle();
            if (t == 0) begin
                checks++; if (gnt !== 2'b10) begin failures++; $display("FAIL rstfold_regrant: got %b, expected 10", gnt); end
            end
            checks++;
            if (rslt_valid !== exp_valid || rslt_cksum !== exp_ck || done_count !== exp_done) begin
                failures++; $display("FAIL rstfold_result t%0d: got valid=%b ck=%h done=%0d, expected valid=%b ck=%h done=%0d", t, rslt_valid, rslt_cksum, done_count, exp_valid, exp_ck, exp_done);
            end
            step();
            req = '0;
        end
    endtask

    task automatic test_random();
        apply_reset();
        step();
        req = '0;
        for (int t = 0; t < 400; t++) begin
            if ($urandom_range(0, 3) == 0) req = NUM_REQ'($urandom);
            rslt_ready = ($urandom_range(0, 3) == 0) ? NUM_REQ'($urandom) : '1;
            rand_sums();
            #1;
            model_cycle();
            checks++;
            if (gnt !== exp_gnt) begin failures++; $display("FAIL rand_gnt t%0d: got %b, expected %b", t, gnt, exp_gnt); end
            checks++;
            if (rslt_valid !== exp_valid || rslt_cksum !== exp_ck) begin
                failures++; $display("FAIL rand_result t%0d: got valid=%b ck=%h, expected valid=%b ck=%h", t, rslt_valid, rslt_cksum, exp_valid, exp_ck);
            end
            checks++;
            if (busy !== exp_busy || done_count !== exp_done) begin
                failures++; $display("FAIL rand_status t%0d: got busy=%b done=%0d, expected busy=%b done=%0d", t, busy, done_count, exp_busy, exp_done);
            end
            step();
        end
        req = '0;
        for (int t = 0; t < 8; t++) begin
            rslt_ready = '1;
            #1;
            model_cycle();
            step();
        end
    endtask

    task automatic test_wrap();
        logic [15:0] ck;
        int lat;
        force dut.r_done_count = 32'hFFFF_FFFF;
        step();
        release dut.r_done_count;
        #1;
        checks++; if (done_count !== 32'hFFFF_FFFF) begin failures++; $display("FAIL wrap_preset: got %h, expected ffffffff", done_count); end
        run_op(0, {32'd0, 32'd0, 32'h0003_0004, 32'h0001_0002}, ck, lat);
        checks++; if (ck !== 16'hFFF5) begin failures++; $display("FAIL wrap_cksum: got %h, expected fff5", ck); end
        checks++; if (done_count !== 32'h0000_0000) begin failures++; $display("FAIL wrap_done: got %h, expected 00000000", done_count); end
    endtask

    initial begin
        AXI_RESETN = 1'b0;
        req        = '0;
        req_sum    = '0;
        rslt_ready = '0;
        model_reset();
        test_reset();
        test_single();
        test_fold();
        test_contention();
        test_backpressure();
        test_reset_fold();
        test_random();
        test_wrap();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire

// File: doc/ip_cksum_sched.md
IP_CKSUM_SCHED -- requirements
Module: ip_cksum_sched

Interface
REQ-001 SHALL have parameter NUM_REQ, default 2, the number of requesters sharing the checksum engine.
REQ-002 SHALL have parameter SUM_WIDTH, default 32, the width of each partial-sum operand.
REQ-003 AXI_ACLK  input  1  sole clock; all state changes on rising edge.
REQ-004 AXI_RESETN  input  1  reset, synchronous, active-low.
REQ-005 req  input  NUM_REQ  per-requester request, level.
REQ-006 req_sum  input  NUM_REQ*4*SUM_WIDTH  four partial sums per requester; requester i occupies slice [i*128 +: 128], operand 0 in the LSBs.
REQ-007 gnt  output  NUM_REQ  one-hot, single-cycle pulse on the cycle the operands are captured.
REQ-008 rslt_valid  output  NUM_REQ  one-hot; result ready for the owning requester.
REQ-009 rslt_ready  input  NUM_REQ  per-requester result acceptance.
REQ-010 rslt_cksum  output  16  final one's-complement checksum; valid only while any rslt_valid bit is high.
REQ-011 busy  output  1  high in every state except IDLE.
REQ-012 done_count  output  32  number of completed result handshakes.

Function
REQ-013 SHALL implement states IDLE, ADD, FOLD, RESP.
REQ-014 IDLE: when any req bit is high, SHALL choose a winner by round-robin, starting the search at (last_owner+1) mod NUM_REQ.
REQ-015 IDLE: on that same cycle SHALL capture the winner's four operands, pulse gnt[winner], record the winner as owner and as last_owner, and go to ADD.
REQ-016 ADD: SHALL form acc = op0+op1+op2+op3 at SUM_WIDTH+2 bits (34 bits at default), with no truncation, then go to FOLD.
REQ-017 FOLD: SHALL run exactly 3 cycles; each cycle acc <= acc[15:0] + acc[upper:16], zero-extended. A 2-bit counter SHALL track the iterations.
REQ-018 After the third fold, acc[upper:16] SHALL be zero, and the block SHALL go to RESP.
REQ-019 RESP: rslt_cksum SHALL equal ~acc[15:0], and rslt_valid[owner] SHALL be high, held stable until rslt_ready[owner] is sampled high.
REQ-020 Handshake cycle (rslt_valid & rslt_ready): done_count SHALL increment, wrapping at 2^32, and the block SHALL return to IDLE on the next cycle.
REQ-021 Latency: with gnt on cycle 0, rslt_valid SHALL rise on cycle 5.
REQ-022 Minimum issue interval: 6 cycles per request, given immediate rslt_ready.
REQ-023 rslt_ready bits of non-owners SHALL be ignored.
REQ-024 A req change after capture SHALL have no effect on the operation in flight.
REQ-025 A requester still asserting req in RESP SHALL NOT be regranted until the next IDLE arbitration.
REQ-026 With all req bits set continuously, grants SHALL rotate 0,1,...,NUM_REQ-1,0,... with no starvation.
REQ-027 No gnt SHALL be issued outside IDLE. Requests arriving while busy SHALL wait, with no loss.
REQ-028 All-zero operands SHALL yield rslt_cksum 0xFFFF.

Reset
REQ-029 While AXI_RESETN is low at a clock edge, the following SHALL hold:
- state = IDLE
- last_owner = NUM_REQ-1, so req[0] wins first after reset
- gnt = 0, rslt_valid = 0, busy = 0
- rslt_cksum = 0x0000, done_count = 0
- operand, accumulator and fold-counter registers = 0
REQ-030 A reset asserted mid-operation (ADD, FOLD or RESP) SHALL abandon the operation. No rslt_valid SHALL appear for it, and done_count SHALL be unchanged by it.

Structure
REQ-031 A shared package SHALL hold:
- state encoding constants
- FOLD_CYCLES = 3
- CKSUM_WIDTH = 16
- operand count per requester = 4
REQ-032 The round-robin selection SHALL be a sub-module, rr_arbiter: inputs req and last_owner; outputs a one-hot grant and its index; purely combinational.
REQ-033 All sequential state SHALL reside in ip_cksum_sched.

Verification
REQ-034 Single request, req[0]=1, operands 0x00010002, 0x00030004, 0, 0, rslt_ready tied high:
- gnt[0] pulses on cycle 0
- rslt_valid[0] on cycle 5 with rslt_cksum 0xFFF5
- done_count = 1
REQ-035 Fold check, all operands 0xFFFFFFFF -> rslt_cksum 0x0000. All operands 0 -> rslt_cksum 0xFFFF.
REQ-036 Contention, req=2'b11 held for 4 operations:
- grant order 0,1,0,1
- gnt pulses 6 cycles apart
- each rslt_valid bit appears only for its owner
REQ-037 Backpressure, rslt_ready[1]=0 for 10 cycles during RESP, with req[0] high:
- rslt_valid[1] and rslt_cksum stay stable
- no gnt[0] until the cycle after the handshake completes
REQ-038 Reset in FOLD, AXI_RESETN low for 1 cycle:
- all outputs return to reset values
- no rslt_valid for the aborted operation
- the next req[1]-only request is granted normally
REQ-039 Counter wrap: force done_count to 0xFFFFFFFF, complete one handshake -> done_count = 0x00000000.
